// File: rtl/mdu_arbiter.sv
// Two-requester round-robin front end for a single multiply/divide unit.
// Holds one operation at a time: grant, issue, wait for result, return response.
module mdu_arbiter #(
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [5:0]            req_op_i,
    input  logic [2*DATA_W-1:0]   req_a_i,
    input  logic [2*DATA_W-1:0]   req_b_i,
    input  logic [2*TAG_W-1:0]    req_tag_i,
    output logic                  mdu_valid_o,
    input  logic                  mdu_ready_i,
    output logic [2:0]            mdu_op_o,
    output logic [DATA_W-1:0]     mdu_a_o,
    output logic [DATA_W-1:0]     mdu_b_o,
    input  logic                  mdu_res_valid_i,
    input  logic [DATA_W-1:0]     mdu_res_i,
    output logic [1:0]            resp_valid_o,
    input  logic [1:0]            resp_ready_i,
    output logic [DATA_W-1:0]     resp_data_o,
    output logic [TAG_W-1:0]      resp_tag_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic                r_ptr;
    logic                r_owner;
    logic [2:0]          r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [TAG_W-1:0]    r_tag;
    logic [DATA_W-1:0]   r_res;

    logic                w_grant;
    logic                w_accept;
    logic                w_capture;
    logic [2:0]          w_op;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [TAG_W-1:0]    w_tag;

    always_comb begin
        // The preferred requester wins if valid, otherwise the other one.
        w_grant   = req_valid_i[r_ptr] ? r_ptr : ~r_ptr;
        w_accept  = (r_state == StIdle) && !flush && !rst && (|req_valid_i);
        w_capture = (r_state == StWait) && !flush && mdu_res_valid_i;
        w_op      = w_grant ? req_op_i[5:3] : req_op_i[2:0];
        w_a       = w_grant ? req_a_i[2*DATA_W-1:DATA_W] : req_a_i[DATA_W-1:0];
        w_b       = w_grant ? req_b_i[2*DATA_W-1:DATA_W] : req_b_i[DATA_W-1:0];
        w_tag     = w_grant ? req_tag_i[2*TAG_W-1:TAG_W] : req_tag_i[TAG_W-1:0];
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept)                w_state_next = StIssue;
            StIssue: if (mdu_ready_i)             w_state_next = StWait;
            StWait:  if (mdu_res_valid_i)         w_state_next = StResp;
            StResp:  if (resp_ready_i[r_owner])   w_state_next = StIdle;
        endcase
        if (flush) begin
            w_state_next = StIdle;
        end
    end

    always_comb begin
        req_ready_o  = 2'b00;
        resp_valid_o = 2'b00;
        if (w_accept) begin
            req_ready_o[w_grant] = 1'b1;
        end
        if ((r_state == StResp) && !flush) begin
            resp_valid_o[r_owner] = 1'b1;
        end
        mdu_valid_o = (r_state == StIssue) && !flush;
        mdu_op_o    = r_op;
        mdu_a_o     = r_a;
        mdu_b_o     = r_b;
        resp_data_o = r_res;
        resp_tag_o  = r_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_tag   <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_next;
            if (flush) begin
                // Drop the operation; ptr keeps its value so fairness survives a flush.
                r_owner <= 1'b0;
                r_op    <= '0;
                r_a     <= '0;
                r_b     <= '0;
                r_tag   <= '0;
                r_res   <= '0;
            end else begin
                if (w_accept) begin
                    r_owner <= w_grant;
                    r_ptr   <= ~w_grant;
                    r_op    <= w_op;
                    r_a     <= w_a;
                    r_b     <= w_b;
                    r_tag   <= w_tag;
                end
                if (w_capture) begin
                    r_res <= mdu_res_i;
                end
            end
        end
    end

endmodule

// File: doc/mdu_arbiter.md
MDU_ARBITER -- requirements
Module: mdu_arbiter

Interface
REQ-001 The block SHALL have parameter TAG_W, default 6, the requester tag width.
REQ-002 The block SHALL have parameter DATA_W, default 32, the operand and result width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 The block SHALL have port req_valid_i  input  2  per-requester request valid.
REQ-007 The block SHALL have port req_ready_o  output  2  per-requester request accept.
REQ-008 The block SHALL have port req_op_i  input  2x3  per-requester MDU opcode.
REQ-009 The block SHALL have ports req_a_i and req_b_i  input  2xDATA_W  per-requester operands.
REQ-010 The block SHALL have port req_tag_i  input  2xTAG_W  per-requester tag.
REQ-011 The block SHALL have port mdu_valid_o  output  1  operation presented to the MDU.
REQ-012 The block SHALL have port mdu_ready_i  input  1  MDU accepts the operation.
REQ-013 The block SHALL have ports mdu_op_o (3), mdu_a_o and mdu_b_o (DATA_W)  output  the latched operation.
REQ-014 The block SHALL have ports mdu_res_valid_i (1) and mdu_res_i (DATA_W)  input  MDU result strobe and data.
REQ-015 The block SHALL have port resp_valid_o  output  2  per-requester response valid.
REQ-016 The block SHALL have port resp_ready_i  input  2  per-requester response accept.
REQ-017 The block SHALL have ports resp_data_o (DATA_W) and resp_tag_o (TAG_W)  output  shared response payload.

Function
REQ-018 The block SHALL implement a four-state FSM, IDLE, ISSUE, WAIT and RESP, with at most one operation in flight.
REQ-019 In IDLE, it SHALL grant one valid requester by round-robin: pointer ptr (1 bit) names the preferred requester, and the other requester wins only when ptr's requester is invalid.
REQ-020 req_ready_o SHALL be asserted only for the granted requester and only in IDLE with flush low; the value may depend combinationally on req_valid_i.
REQ-021 On acceptance, it SHALL latch op, a, b, tag and owner, set ptr to ~owner, and enter ISSUE.
REQ-022 ptr SHALL change only on acceptance.
REQ-023 In ISSUE, mdu_valid_o SHALL be 1 with stable mdu_op_o, mdu_a_o and mdu_b_o until mdu_ready_i; on that handshake the FSM SHALL enter WAIT.
REQ-024 In WAIT, the block SHALL capture mdu_res_i into a result register on mdu_res_valid_i and enter RESP.
REQ-025 mdu_res_valid_i SHALL be ignored in every state other than WAIT.
REQ-026 In RESP, resp_valid_o[owner] SHALL be 1 with resp_data_o set to the captured result and resp_tag_o set to the latched tag, held stable until resp_ready_i[owner].
REQ-027 After the RESP handshake, the FSM SHALL return to IDLE.
REQ-028 resp_valid_o[~owner] SHALL always be 0.
REQ-029 No request SHALL be accepted in the cycle of the RESP handshake, giving a one-cycle bubble.
REQ-030 Minimum latency SHALL be: accept at cycle N, mdu_valid_o at N+1, resp_valid_o at cycle R+1 when the result strobe arrives at cycle R.
REQ-031 Flush SHALL take priority over every other event: the next state SHALL be IDLE and the latched operation and result SHALL be discarded.
REQ-032 While flush is high, req_ready_o, mdu_valid_o and resp_valid_o SHALL all be 0 in that cycle.
REQ-033 ptr SHALL be unchanged by flush.
REQ-034 A flush in the same cycle as an ISSUE handshake or a result strobe SHALL still drop the operation; no response SHALL be produced.
REQ-035 Operand and opcode values SHALL pass through unmodified, with no width conversion.

Reset
REQ-036 While rst is high, the state SHALL be IDLE, ptr SHALL be 0, and req_ready_o, mdu_valid_o and resp_valid_o SHALL all be 0.
REQ-037 While rst is high, all latched op, operand, tag, owner and result registers SHALL be 0.
REQ-038 Reset asserted mid-operation SHALL abandon the operation immediately, without waiting for a clock edge, and no response SHALL follow.

Verification
REQ-039 Both requesters valid at reset exit, with mdu_ready_i=1, result 3 cycles later -> requester 0 is served first; after that response, requester 1 is granted in the next IDLE cycle.
REQ-040 Requester 1 alone, tag 0x2A, a=7, b=6, op MUL -> mdu_a_o=7 and mdu_b_o=6 at N+1; mdu_res_i=42 -> resp_valid_o=2'b10, resp_data_o=42, resp_tag_o=0x2A.
REQ-041 mdu_ready_i held low 5 cycles -> mdu_valid_o and its payload stay stable for 5 cycles; the handshake occurs on cycle 6.
REQ-042 resp_ready_i low 4 cycles with requester 0 valid -> req_ready_o stays 0 and the response payload stays stable.
REQ-043 Flush in WAIT, followed by a result strobe -> no resp_valid_o, FSM in IDLE, next request accepted normally.
REQ-044 Async rst pulse mid-WAIT between clock edges -> outputs go to 0 immediately and ptr=0 afterwards.
